// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-cycle registered imem read, stall hold,
// zero-bubble redirect and halt after the programmed last address.
module fetch_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(9)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_valid,
    output logic                  halted
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_if;
    logic                  vld_if;
    logic                  issue;

    assign issue = redirect | ((state == RUN) & ~stall);

    // Without an issue the word on imem_data is re-read so it stays put.
    always_comb begin
        if (rst)
            imem_addr = RESET_PC;
        else if (redirect)
            imem_addr = redirect_pc;
        else if (issue)
            imem_addr = pc_q;
        else
            imem_addr = pc_if;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            pc_if  <= RESET_PC;
            vld_if <= 1'b0;
            state  <= RUN;
        end else if (issue) begin
            pc_if  <= imem_addr;
            pc_q   <= imem_addr + ADDR_WIDTH'(1);
            vld_if <= 1'b1;
            state  <= (imem_addr == LAST_PC) ? HALT : RUN;
        end else if (!stall) begin
            vld_if <= 1'b0;
        end
    end

    assign if_instr = imem_data;
    assign if_pc    = pc_if;
    assign if_valid = vld_if & ~redirect;
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random/directed stimulus against a
// program-flow reference model; a second instance covers address wrap.
module tb_fetch_unit;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] instr;
    } inst_t;

    typedef struct {
        logic       hlt;
        logic [9:0] addr;
    } cyc_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;
    logic        if_valid;
    logic        halted;

    logic        rst_b;
    logic        stall_b;
    logic        redirect_b;
    logic [9:0]  redirect_pc_b;
    logic [9:0]  imem_addr_b;
    logic [31:0] imem_data_b;
    logic [31:0] if_instr_b;
    logic [9:0]  if_pc_b;
    logic        if_valid_b;
    logic        halted_b;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;
    logic b_done = 1'b0;

    inst_t inst_q[$];
    cyc_t  cyc_q[$];

    // Reference model: shown instruction, next sequential address, halt flag
    logic [9:0] m_pc;
    logic       m_live;
    logic [9:0] m_nxt;
    logic       m_hlt;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr),
        .imem_data(imem_data), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .halted(halted)
    );

    fetch_unit #(
        .RESET_PC(10'd1022),
        .LAST_PC(10'd1023)
    ) dut_b (
        .clk(clk), .rst(rst_b), .stall(stall_b), .redirect(redirect_b),
        .redirect_pc(redirect_pc_b), .imem_addr(imem_addr_b),
        .imem_data(imem_data_b), .if_instr(if_instr_b), .if_pc(if_pc_b),
        .if_valid(if_valid_b), .halted(halted_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        imem_data   <= mem_a[imem_addr];
        imem_data_b <= mem_b[imem_addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc_t  c;
            inst_t e;
            if (cyc_q.size() == 0) begin
                chk("cycle_queue_empty", 1, 0);
            end else begin
                c = cyc_q.pop_front();
                chk("halted", 32'(halted), 32'(c.hlt));
                chk("imem_addr", 32'(imem_addr), 32'(c.addr));
            end
            if (if_valid) begin
                if (inst_q.size() == 0) begin
                    chk("unexpected_valid", 32'(if_pc), 32'hffff_ffff);
                end else begin
                    e = inst_q.pop_front();
                    chk("if_pc", 32'(if_pc), 32'(e.pc));
                    chk("if_instr", if_instr, e.instr);
                end
            end
        end
    end

    task automatic model_reset();
        m_pc   = 10'd0;
        m_live = 1'b0;
        m_nxt  = 10'd0;
        m_hlt  = 1'b0;
    endtask

    // One cycle: apply inputs, record what this cycle must show, advance.
    task automatic step(input logic s, input logic r, input logic [9:0] rp);
        cyc_t c;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        c.hlt = m_hlt;
        if (r)
            c.addr = rp;
        else if (!m_hlt && !s)
            c.addr = m_nxt;
        else
            c.addr = m_pc;
        cyc_q.push_back(c);
        if (m_live && !r)
            inst_q.push_back('{pc: m_pc, instr: mem_a[m_pc]});
        if (r) begin
            m_pc   = rp;
            m_live = 1'b1;
            m_nxt  = rp + 10'd1;
            m_hlt  = (rp == 10'd9);
        end else if (s) begin
            m_pc = m_pc;
        end else if (m_hlt) begin
            m_live = 1'b0;
        end else begin
            m_pc   = m_nxt;
            m_live = 1'b1;
            m_hlt  = (m_nxt == 10'd9);
            m_nxt  = m_nxt + 10'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input logic [9:0] pc);
        int n;
        n = 0;
        while (!(m_live && m_pc == pc) && n < 40) begin
            step(1'b0, 1'b0, 10'd0);
            n++;
        end
        if (n >= 40)
            chk("run_until_timeout", 32'(m_pc), 32'(pc));
    endtask

    // Called at posedge+1; checks the asynchronous effect then restarts.
    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_if_pc", 32'(if_pc), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_inst_q_drained", inst_q.size(), 0);
        inst_q.delete();
        cyc_q.delete();
        stall = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 10'd0;
        #2;
        rst = 1'b1;
        #1;
        chk("por_if_valid", 32'(if_valid), 0);
        chk("por_if_pc", 32'(if_pc), 0);
        chk("por_halted", 32'(halted), 0);
        chk("por_imem_addr", 32'(imem_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++)
            step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b1, 10'd1);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 10'd0);

        step(1'b0, 1'b1, 10'd0);
        run_until(10'd4);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 10'd0);
        run_until(10'd6);
        step(1'b0, 1'b1, 10'd2);
        run_until(10'd3);
        step(1'b1, 1'b1, 10'd7);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 10'd0);

        for (int i = 0; i < 400; i++) begin
            logic s;
            logic r;
            s = ($urandom_range(0, 9) < 3);
            r = m_hlt ? ($urandom_range(0, 9) < 3)
                      : ($urandom_range(0, 9) == 0);
            step(s, r, 10'($urandom_range(0, 9)));
        end

        step(1'b0, 1'b1, 10'd0);
        run_until(10'd5);
        step(1'b1, 1'b0, 10'd0);
        stall = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 10'd0);
        mon_en = 1'b0;

        for (int i = 0; i < 20 && !b_done; i++)
            @(posedge clk);
        chk("b_done", 32'(b_done), 1);
        chk("inst_q_left", inst_q.size(), 0);
        chk("cyc_q_left", cyc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Wrap case: RESET_PC=1022, LAST_PC=1023
    initial begin
        rst_b = 1'b0;
        stall_b = 1'b0;
        redirect_b = 1'b0;
        redirect_pc_b = 10'd0;
        #2;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_first_valid", 32'(if_valid_b), 0);
        chk("b_first_pc", 32'(if_pc_b), 1022);
        @(negedge clk);
        chk("b_valid0", 32'(if_valid_b), 1);
        chk("b_pc0", 32'(if_pc_b), 1022);
        chk("b_instr0", if_instr_b, mem_b[1022]);
        chk("b_halted0", 32'(halted_b), 0);
        @(negedge clk);
        chk("b_valid1", 32'(if_valid_b), 1);
        chk("b_pc1", 32'(if_pc_b), 1023);
        chk("b_instr1", if_instr_b, mem_b[1023]);
        chk("b_halted1", 32'(halted_b), 1);
        chk("b_pc_q_wrap", 32'(dut_b.pc_q), 0);
        @(negedge clk);
        chk("b_valid2", 32'(if_valid_b), 0);
        chk("b_halted2", 32'(halted_b), 1);
        chk("b_addr2", 32'(imem_addr_b), 1023);
        b_done = 1'b1;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS_CPU pipeline, directly upstream of `instructionmemory`. It holds the program counter and drives the word address into the instruction memory, whose read is registered: one cycle of latency. It pairs each returned instruction word with its PC and a valid flag for the decode stage. It handles pipeline stalls without losing the in-flight instruction, takes branch/jump redirects with no bubble, and halts after fetching a programmed last address.

## Interface
- `ADDR_WIDTH`, 10: word-address width; matches instruction-memory depth.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 0: first word address fetched after reset.
- `LAST_PC`, 9: last word address of the program; issuing it halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  decode not accepting; hold the current output.
- `redirect`  in  1  branch/jump taken; fetch restarts at `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  redirect target word address.
- `imem_addr`  out  ADDR_WIDTH  address to instruction memory.
- `imem_data`  in  DATA_WIDTH  instruction memory registered output.
- `if_instr`  out  DATA_WIDTH  instruction to decode; equals `imem_data`.
- `if_pc`  out  ADDR_WIDTH  word address of `if_instr`.
- `if_valid`  out  1  `if_instr`/`if_pc` are a live instruction.
- `halted`  out  1  fetch stopped at `LAST_PC`.

## Operation
State registers:
- `pc_q` holds the next address to issue.
- `pc_if` holds the address whose data is on `imem_data`.
- `vld_if` marks that data as live.
- `state` is RUN or HALT.

Issue rules:
- `issue` = `redirect` OR (`state`==RUN AND NOT `stall`).
- `imem_addr` = `redirect_pc` if `redirect`; else `pc_q` if `issue`; else `pc_if`.
  - The non-issue case re-reads the same word, so the stalled instruction stays on `imem_data`.
- On an edge with `issue`: `pc_if` <= `imem_addr`; `pc_q` <= `imem_addr`+1, modulo 2^ADDR_WIDTH (1023 wraps to 0); `vld_if` <= 1.
- On an edge without `issue`:
  - If `stall`: `pc_q`, `pc_if` and `vld_if` hold.
  - Otherwise (only possible in HALT): `vld_if` <= 0.

Outputs:
- `if_instr` = `imem_data`, combinational passthrough.
- `if_pc` = `pc_if`.
- `if_valid` = `vld_if` AND NOT `redirect`: the wrong-path instruction is killed in the redirect cycle.

State machine:
- RUN -> HALT on any issue edge where `imem_addr`==`LAST_PC`, including a redirect to `LAST_PC`.
- HALT -> RUN on a redirect edge with `redirect_pc` != `LAST_PC`. A redirect to `LAST_PC` issues it and stays in HALT.
- HALT with no redirect: no issue; the `LAST_PC` instruction is delivered, and `vld_if` drops on the first non-stalled edge after it.
- `halted` = (`state`==HALT).

Priority is `rst` > `redirect` > `stall`. A redirect during a stall overrides it.

## Timing
- Reset, asynchronous and immediate:
  - Registers: `pc_q`=`RESET_PC`, `pc_if`=`RESET_PC`, `vld_if`=0, `state`=RUN.
  - Outputs: `if_valid`=0, `if_pc`=`RESET_PC`, `halted`=0.
  - While `rst` is high, `imem_addr`=`RESET_PC` regardless of other inputs.
- First edge after release, with no stall: `RESET_PC` is issued. The following cycle shows `if_valid`=1, `if_pc`=`RESET_PC`, `if_instr`=mem[`RESET_PC`].
- Fetch latency is 1 cycle from issue edge to valid output.
- Throughput is 1 instruction per cycle with no stall.
- Stall:
  - Output holds for every cycle `stall` is high.
  - The next instruction (`if_pc`+1) appears one cycle after the first non-stalled edge.
- Redirect:
  - In the redirect cycle, `if_valid`=0 combinationally.
  - The next cycle shows `if_pc`=`redirect_pc`, `if_valid`=1: zero-bubble.
- Reset mid-operation (for example during a stall or in HALT) aborts everything. Restart is as after power-up.
- All outputs except `imem_addr`, `if_instr` and `if_valid` are driven directly from registers.

## Test plan
- Reset, then run with `RESET_PC`=0, `LAST_PC`=9, memory preloaded with words 0..9 -> `if_pc` 0,1,…,9 on consecutive cycles, each with its word and `if_valid`=1. `halted`=1 from the cycle `if_pc`=9 appears. `if_valid`=0 from the next cycle on, and `imem_addr` stays 9.
- Stall held 3 cycles while `if_pc`=4 -> `if_pc`=4 and word 4 held for 3 extra cycles, with no word skipped or duplicated. `if_pc`=5 appears one cycle after `stall` falls.
- `redirect`=1 with `redirect_pc`=2 while `if_pc`=6 -> `if_valid`=0 that cycle. Next cycle shows `if_pc`=2, then 3, 4.
- Redirect and stall asserted together while `if_pc`=3, `redirect_pc`=7 -> redirect wins; next cycle shows `if_pc`=7, `if_valid`=1.
- In HALT, redirect to 1 -> `halted` falls; `if_pc` runs 1, 2, … until 9, then halts again. Separately, `LAST_PC`=1023 with `RESET_PC`=1022 -> `if_pc` shows 1022, then 1023, then `halted`=1, and `pc_q` has wrapped to 0.
- Assert `rst` mid-stream while `if_pc`=5 and `stall`=1 -> `if_valid`, `halted` and `if_pc` are 0 immediately, without waiting for a clock edge. After release, fetch restarts at 0.
